// File: rtl/predicate_access_scheduler.sv
// Front-end for predicate_register_block. It merges issue-stage reads, writeback writes and a
// per-warp bulk clear onto register-block ports that all share one warp_selector.
module predicate_access_scheduler #(
    parameter int NUM_LANES = 8,
    parameter int NUM_REGS  = 16,
    parameter int NUM_WARPS = 16,
    localparam int RA = $clog2(NUM_REGS),
    localparam int WA = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 rst,

    // Handshake: a request transfers in a cycle where valid and ready are both 1. The requester
    // holds every field stable until that cycle. rd_ready, wr_ready and clr_ready are
    // combinational in the current inputs and state. rd_ready and wr_ready are the grants.
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [WA-1:0]        rd_warp,
    input  logic [RA-1:0]        rd_addr0,
    input  logic [RA-1:0]        rd_addr1,
    input  logic [NUM_LANES-1:0] rd_mask,
    output logic                 rsp_valid,
    output logic [NUM_LANES-1:0] rsp_data0,
    output logic [NUM_LANES-1:0] rsp_data1,

    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [WA-1:0]        wr_warp,
    input  logic [RA-1:0]        wr_addr,
    input  logic [NUM_LANES-1:0] wr_mask,
    input  logic [NUM_LANES-1:0] wr_data,

    input  logic                 clr_valid,
    output logic                 clr_ready,
    input  logic [WA-1:0]        clr_warp,
    output logic                 clr_done,

    output logic [NUM_LANES-1:0] pr_read_en_0,
    output logic [NUM_LANES-1:0] pr_read_en_1,
    output logic [RA-1:0]        pr_raddr_0,
    output logic [RA-1:0]        pr_raddr_1,
    output logic [NUM_LANES-1:0] pr_write_en,
    output logic [RA-1:0]        pr_waddr,
    output logic [NUM_LANES-1:0] pr_wdata,
    output logic [WA-1:0]        pr_warp_selector,
    input  logic [NUM_LANES-1:0] pr_rdata_0,
    input  logic [NUM_LANES-1:0] pr_rdata_1,

    output logic [0:0]           dbg_state_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [RA-1:0] LAST_REG = RA'(NUM_REGS - 1);

    logic [0:0]           state_q, state_d;
    logic [RA-1:0]        cnt_q, cnt_d;
    logic [WA-1:0]        clr_w_q, clr_w_d;
    logic                 prio_q, prio_d;      // 0: write wins a cross-warp conflict
    logic [WA-1:0]        sel_q, sel_d;
    logic                 done_q, done_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [NUM_LANES-1:0] rsp0_q, rsp0_d;
    logic [NUM_LANES-1:0] rsp1_q, rsp1_d;

    logic in_idle;
    logic clear_active;
    logic conflict;
    logic rd_grant;
    logic wr_grant;
    logic clr_accept;

    assign in_idle      = (state_q == ST_IDLE);
    assign clear_active = (state_q == ST_CLEAR) && !rst;
    assign conflict     = !rst && in_idle && rd_valid && wr_valid && (rd_warp != wr_warp);

    always_comb begin
        rd_grant = 1'b0;
        wr_grant = 1'b0;
        if (!rst) begin
            if (in_idle) begin
                if (rd_valid && wr_valid) begin
                    if (rd_warp == wr_warp) begin
                        rd_grant = 1'b1;
                        wr_grant = 1'b1;
                    end else if (prio_q) begin
                        rd_grant = 1'b1;
                    end else begin
                        wr_grant = 1'b1;
                    end
                end else begin
                    rd_grant = rd_valid;
                    wr_grant = wr_valid;
                end
            end else begin
                // The clear owns the selector, so only reads of the clearing warp can share it.
                rd_grant = rd_valid && (rd_warp == clr_w_q);
            end
        end
    end

    assign rd_ready   = rd_grant;
    assign wr_ready   = wr_grant;
    assign clr_ready  = in_idle && !rst;
    assign clr_accept = clr_valid && clr_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_w_d = clr_w_q;
        done_d  = 1'b0;
        prio_d  = conflict ? ~prio_q : prio_q;
        if (clr_accept) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
            clr_w_d = clr_warp;
        end else if (clear_active) begin
            if (cnt_q == LAST_REG) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + RA'(1);
            end
        end
    end

    always_comb begin
        pr_read_en_0 = '0;
        pr_read_en_1 = '0;
        pr_raddr_0   = '0;
        pr_raddr_1   = '0;
        if (rd_grant) begin
            pr_read_en_0 = rd_mask;
            pr_read_en_1 = rd_mask;
            pr_raddr_0   = rd_addr0;
            pr_raddr_1   = rd_addr1;
        end
    end

    always_comb begin
        pr_write_en = '0;
        pr_waddr    = '0;
        pr_wdata    = '0;
        if (clear_active) begin
            pr_write_en = {NUM_LANES{1'b1}};
            pr_waddr    = cnt_q;
        end else if (wr_grant) begin
            pr_write_en = wr_mask;
            pr_waddr    = wr_addr;
            pr_wdata    = wr_data;
        end
    end

    // With no access the selector keeps its last driven value to avoid needless toggling.
    always_comb begin
        sel_d = sel_q;
        if (clear_active) begin
            sel_d = clr_w_q;
        end else if (wr_grant) begin
            sel_d = wr_warp;
        end else if (rd_grant) begin
            sel_d = rd_warp;
        end
    end

    assign pr_warp_selector = sel_d;

    always_comb begin
        rsp_valid_d = rd_grant;
        rsp0_d      = rsp0_q;
        rsp1_d      = rsp1_q;
        if (rd_grant) begin
            rsp0_d = pr_rdata_0 & rd_mask;
            rsp1_d = pr_rdata_1 & rd_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            clr_w_q     <= '0;
            prio_q      <= 1'b0;
            sel_q       <= '0;
            done_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp0_q      <= '0;
            rsp1_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clr_w_q     <= clr_w_d;
            prio_q      <= prio_d;
            sel_q       <= sel_d;
            done_q      <= done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp0_q      <= rsp0_d;
            rsp1_q      <= rsp1_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data0   = rsp0_q;
    assign rsp_data1   = rsp1_q;
    assign clr_done    = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_predicate_access_scheduler.sv
// Bench for predicate_access_scheduler: a behavioural register block, a spec-level cycle model,
// an arbitration vector table, directed clear/reset sequences and randomized traffic.
module tb_predicate_access_scheduler;

    localparam int NL = 8;
    localparam int NR = 16;
    localparam int NW = 16;
    localparam int RA = 4;
    localparam int WA = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_valid, rd_ready, rsp_valid;
    logic [WA-1:0] rd_warp;
    logic [RA-1:0] rd_addr0, rd_addr1;
    logic [NL-1:0] rd_mask, rsp_data0, rsp_data1;
    logic          wr_valid, wr_ready;
    logic [WA-1:0] wr_warp;
    logic [RA-1:0] wr_addr;
    logic [NL-1:0] wr_mask, wr_data;
    logic          clr_valid, clr_ready, clr_done;
    logic [WA-1:0] clr_warp;
    logic [NL-1:0] pr_read_en_0, pr_read_en_1, pr_write_en, pr_wdata, pr_rdata_0, pr_rdata_1;
    logic [RA-1:0] pr_raddr_0, pr_raddr_1, pr_waddr;
    logic [WA-1:0] pr_warp_selector;
    logic [0:0]    dbg_state;

    always #5 clk = ~clk;

    predicate_access_scheduler #(.NUM_LANES(NL), .NUM_REGS(NR), .NUM_WARPS(NW)) dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_warp(rd_warp), .rd_addr0(rd_addr0),
        .rd_addr1(rd_addr1), .rd_mask(rd_mask), .rsp_valid(rsp_valid), .rsp_data0(rsp_data0),
        .rsp_data1(rsp_data1),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_warp(wr_warp), .wr_addr(wr_addr),
        .wr_mask(wr_mask), .wr_data(wr_data),
        .clr_valid(clr_valid), .clr_ready(clr_ready), .clr_warp(clr_warp), .clr_done(clr_done),
        .pr_read_en_0(pr_read_en_0), .pr_read_en_1(pr_read_en_1), .pr_raddr_0(pr_raddr_0),
        .pr_raddr_1(pr_raddr_1), .pr_write_en(pr_write_en), .pr_waddr(pr_waddr),
        .pr_wdata(pr_wdata), .pr_warp_selector(pr_warp_selector), .pr_rdata_0(pr_rdata_0),
        .pr_rdata_1(pr_rdata_1), .dbg_state_o(dbg_state)
    );

    // Behavioural predicate_register_block: combinational read, per-lane write on the clock.
    logic [NL-1:0] env_mem [NW][NR];
    assign pr_rdata_0 = env_mem[pr_warp_selector][pr_raddr_0];
    assign pr_rdata_1 = env_mem[pr_warp_selector][pr_raddr_1];
    always @(posedge clk) begin
        if (|pr_write_en)
            env_mem[pr_warp_selector][pr_waddr] <=
                (env_mem[pr_warp_selector][pr_waddr] & ~pr_write_en) | (pr_wdata & pr_write_en);
    end

    // Reference model state.
    logic [NL-1:0]   ref_mem [NW][NR];
    logic [2*NL-1:0] exp_q[$];
    logic            m_clearing, m_wr_first, m_done, m_rsp_v;
    logic [WA-1:0]   m_clr_warp, m_last_sel, m_sel;
    int              m_writes_done;
    logic [NL-1:0]   m_rsp0, m_rsp1;
    logic            m_rg, m_wg, m_conf, m_clr_rdy;

    // Observed DUT values of the most recent step.
    logic          obs_rd, obs_wr, obs_clr_rdy, obs_rsp_v, obs_done;
    logic [WA-1:0] obs_sel;
    logic [RA-1:0] obs_waddr;
    logic [NL-1:0] obs_we, obs_rsp0, obs_rsp1;
    logic [0:0]    obs_state;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_comb();
        m_rg = 1'b0; m_wg = 1'b0; m_conf = 1'b0; m_clr_rdy = 1'b0;
        if (!rst) begin
            if (!m_clearing) begin
                m_clr_rdy = 1'b1;
                if (rd_valid && wr_valid && rd_warp != wr_warp) begin
                    m_conf = 1'b1;
                    if (m_wr_first) m_wg = 1'b1; else m_rg = 1'b1;
                end else begin
                    m_rg = rd_valid;
                    m_wg = wr_valid;
                end
            end else begin
                m_rg = rd_valid && rd_warp == m_clr_warp;
            end
        end
        if (!rst && m_clearing) m_sel = m_clr_warp;
        else if (m_wg)          m_sel = wr_warp;
        else if (m_rg)          m_sel = rd_warp;
        else                    m_sel = m_last_sel;
    endtask

    task automatic model_edge();
        logic [2*NL-1:0] e;
        if (rst) begin
            m_clearing = 1'b0; m_writes_done = 0; m_done = 1'b0; m_wr_first = 1'b1;
            m_last_sel = '0; m_rsp_v = 1'b0; m_rsp0 = '0; m_rsp1 = '0;
            exp_q.delete();
            return;
        end
        m_rsp_v = m_rg;
        if (m_rg)
            exp_q.push_back({ref_mem[rd_warp][rd_addr0] & rd_mask,
                             ref_mem[rd_warp][rd_addr1] & rd_mask});
        m_done = 1'b0;
        if (m_clearing) begin
            ref_mem[m_clr_warp][m_writes_done] = '0;
            m_writes_done++;
            if (m_writes_done == NR) begin
                m_clearing = 1'b0;
                m_done = 1'b1;
            end
        end else begin
            if (m_wg)
                ref_mem[wr_warp][wr_addr] = (ref_mem[wr_warp][wr_addr] & ~wr_mask) | (wr_data & wr_mask);
            if (clr_valid) begin
                m_clearing = 1'b1;
                m_clr_warp = clr_warp;
                m_writes_done = 0;
            end
        end
        m_last_sel = m_sel;
        if (m_conf) m_wr_first = !m_wr_first;
        if (m_rsp_v && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m_rsp0 = e[2*NL-1:NL];
            m_rsp1 = e[NL-1:0];
        end
    endtask

    // One clock cycle. Inputs are set at the falling edge before the call.
    task automatic step();
        logic [NL-1:0] exp_we, exp_wd, exp_re;
        logic [RA-1:0] exp_wa;
        #1;
        model_comb();
        exp_re = m_rg ? rd_mask : '0;
        exp_we = '0; exp_wa = '0; exp_wd = '0;
        if (!rst && m_clearing) begin
            exp_we = '1; exp_wa = RA'(m_writes_done);
        end else if (m_wg) begin
            exp_we = wr_mask; exp_wa = wr_addr; exp_wd = wr_data;
        end
        chk("rd_ready", 32'(rd_ready), 32'(m_rg));
        chk("wr_ready", 32'(wr_ready), 32'(m_wg));
        chk("clr_ready", 32'(clr_ready), 32'(m_clr_rdy));
        chk("pr_read_en_0", 32'(pr_read_en_0), 32'(exp_re));
        chk("pr_read_en_1", 32'(pr_read_en_1), 32'(exp_re));
        chk("pr_raddr_0", 32'(pr_raddr_0), m_rg ? 32'(rd_addr0) : 32'd0);
        chk("pr_raddr_1", 32'(pr_raddr_1), m_rg ? 32'(rd_addr1) : 32'd0);
        chk("pr_write_en", 32'(pr_write_en), 32'(exp_we));
        chk("pr_waddr", 32'(pr_waddr), 32'(exp_wa));
        chk("pr_wdata", 32'(pr_wdata), 32'(exp_wd));
        if (!rst) chk("pr_warp_selector", 32'(pr_warp_selector), 32'(m_sel));
        obs_rd = rd_ready; obs_wr = wr_ready; obs_clr_rdy = clr_ready;
        obs_sel = pr_warp_selector; obs_we = pr_write_en; obs_waddr = pr_waddr;
        @(posedge clk);
        model_edge();
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
        chk("rsp_data0", 32'(rsp_data0), 32'(m_rsp0));
        chk("rsp_data1", 32'(rsp_data1), 32'(m_rsp1));
        chk("clr_done", 32'(clr_done), 32'(m_done));
        chk("state", 32'(dbg_state), 32'(m_clearing));
        obs_rsp_v = rsp_valid; obs_rsp0 = rsp_data0; obs_rsp1 = rsp_data1;
        obs_done = clr_done; obs_state = dbg_state;
        @(negedge clk);
    endtask

    task automatic do_write(input int w, input int a, input logic [NL-1:0] m, input logic [NL-1:0] d);
        wr_valid = 1'b1; wr_warp = WA'(w); wr_addr = RA'(a); wr_mask = m; wr_data = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input int w, input int a0, input int a1, input logic [NL-1:0] m);
        rd_valid = 1'b1; rd_warp = WA'(w); rd_addr0 = RA'(a0); rd_addr1 = RA'(a1); rd_mask = m;
        step();
        rd_valid = 1'b0;
    endtask

    typedef struct {
        logic          rv;
        logic          wv;
        logic [WA-1:0] rw;
        logic [WA-1:0] ww;
        logic          exp_rd;
        logic          exp_wr;
        logic [WA-1:0] exp_sel;
    } arb_vec_t;

    arb_vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 4'd2, 4'd7, 1'b0, 1'b1, 4'd7};
        tbl[1] = '{1'b1, 1'b1, 4'd2, 4'd7, 1'b1, 1'b0, 4'd2};
        tbl[2] = '{1'b1, 1'b1, 4'd2, 4'd7, 1'b0, 1'b1, 4'd7};
        tbl[3] = '{1'b1, 1'b1, 4'd2, 4'd7, 1'b1, 1'b0, 4'd2};
        tbl[4] = '{1'b1, 1'b0, 4'd5, 4'd0, 1'b1, 1'b0, 4'd5};
        tbl[5] = '{1'b0, 1'b1, 4'd0, 4'd6, 1'b0, 1'b1, 4'd6};
        tbl[6] = '{1'b1, 1'b1, 4'd4, 4'd4, 1'b1, 1'b1, 4'd4};
        tbl[7] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd4};
        tbl[8] = '{1'b1, 1'b1, 4'd1, 4'd2, 1'b0, 1'b1, 4'd2};
        tbl[9] = '{1'b1, 1'b1, 4'd1, 4'd2, 1'b1, 1'b0, 4'd1};

        for (int w = 0; w < NW; w++)
            for (int r = 0; r < NR; r++) begin
                env_mem[w][r] = '0;
                ref_mem[w][r] = '0;
            end
        m_clearing = 1'b0; m_wr_first = 1'b1; m_last_sel = '0; m_writes_done = 0;
        rst = 1'b1;
        rd_valid = 1'b0; rd_warp = '0; rd_addr0 = '0; rd_addr1 = '0; rd_mask = '0;
        wr_valid = 1'b0; wr_warp = '0; wr_addr = '0; wr_mask = '0; wr_data = '0;
        clr_valid = 1'b0; clr_warp = '0;

        // Reset state.
        step();
        step();
        rst = 1'b0;
        chk("reset_rsp_valid", 32'(obs_rsp_v), 32'd0);
        chk("reset_rsp_data0", 32'(obs_rsp0), 32'd0);
        chk("reset_clr_done", 32'(obs_done), 32'd0);
        chk("reset_state", 32'(obs_state), 32'd0);

        // Write then read back on both ports.
        do_write(3, 5, 8'hFF, 8'hA5);
        chk("wr_granted", 32'(obs_wr), 32'd1);
        do_read(3, 5, 5, 8'hFF);
        chk("rd_granted", 32'(obs_rd), 32'd1);
        chk("rd_rsp_valid", 32'(obs_rsp_v), 32'd1);
        chk("rd_rsp0_a5", 32'(obs_rsp0), 32'hA5);
        chk("rd_rsp1_a5", 32'(obs_rsp1), 32'hA5);

        // Arbitration table.
        for (int i = 0; i < 10; i++) begin
            rd_valid = tbl[i].rv; rd_warp = tbl[i].rw; rd_addr0 = '0; rd_addr1 = RA'(1); rd_mask = 8'hFF;
            wr_valid = tbl[i].wv; wr_warp = tbl[i].ww; wr_addr = '0; wr_mask = 8'h0F; wr_data = NL'(i);
            step();
            chk($sformatf("tbl%0d_rd", i), 32'(obs_rd), 32'(tbl[i].exp_rd));
            chk($sformatf("tbl%0d_wr", i), 32'(obs_wr), 32'(tbl[i].exp_wr));
            chk($sformatf("tbl%0d_sel", i), 32'(obs_sel), 32'(tbl[i].exp_sel));
        end
        rd_valid = 1'b0; wr_valid = 1'b0;

        // Same-cycle read and write of one register returns the old value.
        rd_valid = 1'b1; rd_warp = 4'd4; rd_addr0 = 4'd1; rd_addr1 = 4'd1; rd_mask = 8'hFF;
        wr_valid = 1'b1; wr_warp = 4'd4; wr_addr = 4'd1; wr_mask = 8'hFF; wr_data = 8'hFF;
        step();
        rd_valid = 1'b0; wr_valid = 1'b0;
        chk("rw_same_rd", 32'(obs_rd), 32'd1);
        chk("rw_same_wr", 32'(obs_wr), 32'd1);
        chk("rw_same_old", 32'(obs_rsp0), 32'h00);
        do_read(4, 1, 1, 8'hFF);
        chk("rw_same_new", 32'(obs_rsp0), 32'hFF);

        // Fill warp 9 and clear it, with a stalled write and reads during the clear.
        for (int r = 0; r < NR; r++) do_write(9, r, 8'hFF, 8'hFF);
        clr_valid = 1'b1; clr_warp = 4'd9;
        step();
        chk("clr_accept", 32'(obs_clr_rdy), 32'd1);
        clr_valid = 1'b0;
        wr_valid = 1'b1; wr_warp = 4'd1; wr_addr = 4'd2; wr_mask = 8'hFF; wr_data = 8'h3C;
        for (int k = 0; k < NR; k++) begin
            if (k == 3) begin
                rd_valid = 1'b1; rd_warp = 4'd9; rd_addr0 = 4'd3; rd_addr1 = 4'd4; rd_mask = 8'hFF;
            end else if (k == 4) begin
                rd_addr0 = 4'd10; rd_addr1 = 4'd11; rd_mask = 8'h0F;
            end else if (k == 5) begin
                rd_warp = 4'd1; rd_addr0 = 4'd2; rd_addr1 = 4'd2; rd_mask = 8'hFF;
            end
            step();
            chk($sformatf("clr%0d_we", k), 32'(obs_we), 32'hFF);
            chk($sformatf("clr%0d_waddr", k), 32'(obs_waddr), 32'(k));
            chk($sformatf("clr%0d_sel", k), 32'(obs_sel), 32'd9);
            chk($sformatf("clr%0d_wr_ready", k), 32'(obs_wr), 32'd0);
            if (k < NR - 1) chk($sformatf("clr%0d_done", k), 32'(obs_done), 32'd0);
            if (k == 3) begin
                chk("clr_rd_same_warp", 32'(obs_rd), 32'd1);
                chk("clr_rd_prewrite0", 32'(obs_rsp0), 32'hFF);
                chk("clr_rd_prewrite1", 32'(obs_rsp1), 32'hFF);
            end
            if (k == 4) chk("clr_rd_masked", 32'(obs_rsp0), 32'h0F);
            if (k >= 5) chk($sformatf("clr%0d_rd_stall", k), 32'(obs_rd), 32'd0);
        end
        chk("clr_done_pulse", 32'(obs_done), 32'd1);
        step();
        chk("post_clr_rd", 32'(obs_rd), 32'd1);
        chk("post_clr_wr", 32'(obs_wr), 32'd1);
        chk("post_clr_done_low", 32'(obs_done), 32'd0);
        rd_valid = 1'b0; wr_valid = 1'b0;
        for (int r = 0; r < NR; r++) begin
            do_read(9, r, r, 8'hFF);
            chk($sformatf("cleared_r%0d", r), 32'(obs_rsp0), 32'h00);
        end

        // Reset in clear cycle 6 aborts the clear.
        for (int r = 0; r < NR; r++) do_write(9, r, 8'hFF, 8'hFF);
        clr_valid = 1'b1; clr_warp = 4'd9;
        step();
        clr_valid = 1'b0;
        for (int k = 0; k < 6; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("abort%0d_no_done", k), 32'(obs_done), 32'd0);
        end
        chk("abort_state", 32'(obs_state), 32'd0);
        for (int r = 0; r < NR; r++) begin
            do_read(9, r, r, 8'hFF);
            chk($sformatf("abort_r%0d", r), 32'(obs_rsp0), (r < 6) ? 32'h00 : 32'hFF);
        end

        // Randomized traffic against the model; pending requests hold until granted.
        for (int c = 0; c < 1500; c++) begin
            if (!rd_valid && $urandom_range(0, 99) < 60) begin
                rd_valid = 1'b1; rd_warp = WA'($urandom_range(0, 3));
                rd_addr0 = RA'($urandom_range(0, NR - 1)); rd_addr1 = RA'($urandom_range(0, NR - 1));
                rd_mask = NL'($urandom);
            end
            if (!wr_valid && $urandom_range(0, 99) < 50) begin
                wr_valid = 1'b1; wr_warp = WA'($urandom_range(0, 3));
                wr_addr = RA'($urandom_range(0, NR - 1));
                wr_mask = NL'($urandom); wr_data = NL'($urandom);
            end
            if (!clr_valid && $urandom_range(0, 99) < 3) begin
                clr_valid = 1'b1; clr_warp = WA'($urandom_range(0, 3));
            end
            step();
            if (m_rg) rd_valid = 1'b0;
            if (m_wg) wr_valid = 1'b0;
            if (m_clr_rdy && clr_valid) clr_valid = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
